// File: rtl/pipe_result_decoder.sv
// Restoring divider that recovers (a+/-b) from a C*(a+/-b) pipeline result.
// One quotient bit per clock, valid/ready on both sides, with a handshake counter.
module pipe_result_decoder #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  exact,
  output logic                  div_by_zero,
  output logic [CNT_W-1:0]      done_count
);
  localparam int BIT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DIVISOR_W-1:0]  prem_q, prem_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  exact_q, exact_d;
  logic                  dbz_q, dbz_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Stored remainder is always < divisor, so DIVISOR_W bits suffice; the
  // shifted trial value needs one extra bit before the compare.
  logic [DIVISOR_W:0] trial, nxt_prem;
  logic               ge;

  assign trial    = {prem_q, dvd_q[bit_q]};
  assign ge       = trial >= {1'b0, dvs_q};
  assign nxt_prem = ge ? (trial - {1'b0, dvs_q}) : trial;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    exact_d = exact_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = dividend;
          dvs_d = divisor;
          if (divisor != '0) begin
            state_d = CALC;
            bit_d   = BIT_W'(DIVIDEND_W - 1);
            prem_d  = '0;
            quot_d  = '0;
          end else begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
            exact_d = 1'b0;
          end
        end
      end
      CALC: begin
        prem_d = nxt_prem[DIVISOR_W-1:0];
        quot_d = {quot_q[DIVIDEND_W-2:0], ge};
        bit_d  = bit_q - 1'b1;
        if (bit_q == '0) begin
          state_d = DONE;
          rem_d   = nxt_prem[DIVISOR_W-1:0];
          exact_d = (nxt_prem == '0);
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      exact_q <= 1'b0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      exact_q <= exact_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign exact       = exact_q;
  assign div_by_zero = dbz_q;
  assign done_count  = cnt_q;
endmodule

// File: doc/pipe_result_decoder.md
Name: pipe_result_decoder

Overview:
- Inverse of the two-stage C*(A±B) datapath: recovers the sum/difference term from a 16-bit pipeline result by dividing it by the 8-bit multiplier C.
- Iterative restoring divider, one quotient bit per clock, with valid/ready handshakes on both input and output.
- Sits downstream of the pipeline result bus and feeds the self-check and readback logic, which compare quotient against (a±b) and require remainder == 0.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width; equals the pipeline result width.
- DIVISOR_W, 8, divisor and remainder width; equals the c operand width.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  block can accept an operation.
- dividend  input  DIVIDEND_W  pipeline result, unsigned.
- divisor  input  DIVISOR_W  c operand, unsigned.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- quotient  output  DIVIDEND_W  floor(dividend/divisor).
- remainder  output  DIVISOR_W  dividend mod divisor.
- exact  output  1  remainder == 0 and divisor != 0.
- div_by_zero  output  1  divisor was 0.
- done_count  output  CNT_W  number of completed output handshakes; wraps.

Behaviour:
- reset low, at any time and any state:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - quotient, remainder, exact, div_by_zero, done_count, and internal registers all = 0.
- Reset mid-operation aborts the operation with no output. The first accept is allowed on the first rising edge after reset is released.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid = 1, the operands are captured.
  - divisor != 0: go to CALC; bit counter = DIVIDEND_W-1; partial remainder = 0.
  - divisor == 0: go to DONE. Outputs: quotient = all ones, remainder = dividend[DIVISOR_W-1:0], div_by_zero = 1, exact = 0.
- CALC:
  - in_ready = 0.
  - Each edge: shift the next dividend bit (MSB first) into a (DIVISOR_W+1)-bit partial remainder.
  - If partial remainder >= divisor: subtract divisor and set the quotient bit to 1; otherwise set the quotient bit to 0.
  - After the edge that processes bit 0, go to DONE with out_valid = 1. That is exactly DIVIDEND_W edges after the accept edge (16 by default).
  - in_valid is ignored while in CALC.
- DONE:
  - in_ready = 0; out_valid = 1.
  - quotient, remainder, exact and div_by_zero are stable until the output handshake.
  - On an edge with out_ready = 1: go to IDLE, out_valid = 0, done_count increments (wraps from max to 0).
  - Data outputs keep their last values after the handshake; they are valid only while out_valid = 1.
- Throughput:
  - No same-cycle output handshake plus new accept: in_ready rises only in IDLE.
  - Minimum spacing between accepts is DIVIDEND_W+2 cycles with no backpressure.
- Latency from accept to out_valid:
  - divisor != 0: DIVIDEND_W cycles.
  - divisor == 0: 1 cycle.
- Arithmetic: all operands are unsigned; no sign interpretation.
  - A modular result (e.g. s=0 with a<b) decodes as an unsigned quotient.
  - The consumer interprets that quotient modulo 2^16.
- out_ready held high continuously is legal: DONE lasts exactly one cycle.

Test Plan:
- Reset release, then a=10, b=20, c=5, s=1 (dividend 150, divisor 5) -> out_valid rises 16 cycles after accept; quotient 30, remainder 0, exact 1, done_count 1.
- dividend 1000, divisor 7 -> quotient 142, remainder 6, exact 0.
- dividend 65535, divisor 255 -> quotient 257, remainder 0. Then dividend 65535, divisor 1 -> quotient 65535, remainder 0.
- dividend 300, divisor 0 -> out_valid one cycle after accept; div_by_zero 1, quotient 65535, remainder 44, exact 0.
- out_ready held low for 10 cycles in DONE -> outputs stable, in_ready 0, in_valid pulses ignored. Then out_ready = 1 -> IDLE next edge, done_count +1.
- reset driven low 5 cycles into CALC (asynchronous, mid-cycle) -> out_valid 0, in_ready 1, done_count 0 immediately. The next operation (dividend 84, divisor 12) completes with quotient 7, remainder 0.
